// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid queue; entry 0 is always the head.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] ent0_q, ent1_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= din_i;
          else               ent1_q <= din_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; new word lands behind whatever remains
          if (occ_q == 2'd1) begin
            ent0_q <= din_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = ent0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-clock drain engine: pops cmd_len+1 words from a 1-cycle-latency FIFO onto a valid/ready stream.
// state    | meaning
// ST_IDLE  | waiting for a burst command, cmd_ready high
// ST_DRAIN | issuing FIFO pops and delivering beats until the last beat is accepted
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int LEN_W = 8
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [SIZE-1:0]  fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SIZE-1:0]  m_data,
  output logic             m_last,
  output logic             busy
);

  state_e           state_q;
  logic [LEN_W:0]   req_left_q, out_left_q, len_d;
  logic             inflight_q;
  logic [1:0]       occ;
  logic [SIZE-1:0]  head;
  logic             pop;
  logic [2:0]       credit_used, credit_cap;

  assign len_d       = {1'b0, cmd_len} + (LEN_W+1)'(1);
  assign pop         = m_valid && m_ready;
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign credit_cap  = 3'(SKID_DEPTH) + {2'b00, pop};

  // a pop is only issued when the skid is guaranteed room for the returning word
  assign fifo_rd_en = !reset && (state_q == ST_DRAIN) && !fifo_empty &&
                      (req_left_q != '0) && (credit_used < credit_cap);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_DRAIN);
  assign m_valid   = (occ != 2'd0);
  assign m_data    = head;
  assign m_last    = m_valid && (out_left_q == (LEN_W+1)'(1));

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_left_q <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q    <= ST_DRAIN;
            req_left_q <= len_d;
            out_left_q <= len_d;
          end
        end
        ST_DRAIN: begin
          if (fifo_rd_en) req_left_q <= req_left_q - (LEN_W+1)'(1);
          if (pop)        out_left_q <= out_left_q - (LEN_W+1)'(1);
          if (pop && m_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fifo_rd_skid #(.W(SIZE)) u_skid (
    .clk_i  (rd_clk),
    .rst_i  (reset),
    .push_i (inflight_q),
    .din_i  (fifo_data),
    .pop_i  (pop),
    .occ_o  (occ),
    .head_o (head)
  );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO model plus expected-word scoreboard.
module tb_fifo_rd_drain;

  logic        rd_clk = 1'b0;
  logic        reset, cmd_valid, m_ready;
  logic        fifo_empty = 1'b1;
  logic [7:0]  cmd_len;
  logic [31:0] fifo_data = '0;
  logic        cmd_ready, fifo_rd_en, m_valid, m_last, busy;
  logic [31:0] m_data;

  fifo_rd_drain #(.SIZE(32), .LEN_W(8)) dut (
    .rd_clk(rd_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  bit rd_seen = 0, tog_en = 0, force_e = 0;

  int cyc = 0, accept_cnt = 0, accept_cyc = 0, burst_n = 0, beats_seen = 0, rd_cnt = 0;
  int first_rd_cyc = -1, last_rd_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1;
  bit burst_done = 0, prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // FIFO model: 1-cycle registered read, empty flag registered
  always @(posedge rd_clk) begin
    if (rd_seen && fq.size() > 0) fifo_data <= fq.pop_front();
    force_e = tog_en ? ~force_e : 1'b0;
    fifo_empty <= (fq.size() == 0) || force_e;
  end

  // Monitor: sampled mid-cycle, describes what the coming edge will do
  always @(negedge rd_clk) begin
    cyc++;
    rd_seen = fifo_rd_en;
    if (reset) begin
      prev_stall = 0;
    end else begin
      chk("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
      end
      if (prev_stall) begin
        chk("hold_valid", {63'd0, m_valid}, 64'd1);
        chk("hold_data", {32'd0, m_data}, {32'd0, prev_data});
        chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
      end
      if (m_valid)
        chk("last_flag", {63'd0, m_last}, {63'd0, beats_seen == burst_n - 1});
      else
        chk("last_idle", {63'd0, m_last}, 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("beat_data", {32'd0, m_data}, {32'd0, exp_q.pop_front()});
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        beats_seen++;
        if (m_last) begin
          burst_done = 1;
          chk("no_accept_on_last", {63'd0, cmd_ready}, 64'd0);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (cmd_valid && cmd_ready) begin
        accept_cnt++;
        accept_cyc = cyc;
        burst_n = int'(cmd_len) + 1;
        beats_seen = 0; burst_done = 0; rd_cnt = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
      end
    end
  end

  task automatic load(input int n, input bit rnd, input logic [31:0] base);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : base + 32'(i);
      fq.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic issue(input int len);
    int a0, n;
    a0 = accept_cnt;
    n = 0;
    @(posedge rd_clk); #1;
    cmd_valid = 1'b1;
    cmd_len = 8'(len);
    while (accept_cnt == a0 && n < 50) begin
      @(posedge rd_clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", {63'd0, accept_cnt != a0}, 64'd1);
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    int n;
    n = 0;
    while (!burst_done && n < maxc) begin
      @(posedge rd_clk); #1;
      n++;
      if (!burst_done && rnd) begin
        m_ready = 1'($urandom_range(0, 1));
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_len = 8'($urandom);
      end
    end
    cmd_valid = 1'b0;
    m_ready = 1'b1;
    chk("burst_timeout", {63'd0, burst_done}, 64'd1);
    @(negedge rd_clk);
    chk("post_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("post_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, len;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b0;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("rst_m_data", {32'd0, m_data}, 64'd0);
    @(posedge rd_clk); #1;
    reset = 1'b0; m_ready = 1'b1;

    // 4-beat burst at full rate
    load(4, 0, 32'hA0);
    issue(3);
    wait_done(50, 0);
    chk("b4_beats", 64'(beats_seen), 64'd4);
    chk("b4_rd_cnt", 64'(rd_cnt), 64'd4);
    chk("b4_first_rd", 64'(first_rd_cyc), 64'(accept_cyc + 1));
    chk("b4_rd_span", 64'(last_rd_cyc - first_rd_cyc), 64'd3);
    chk("b4_pop_span", 64'(last_pop_cyc - first_pop_cyc), 64'd3);

    // 8-beat burst with a 5-cycle stall on beat 2
    load(8, 0, 32'hB0);
    issue(7);
    n = 0;
    while (beats_seen < 2 && n < 50) begin
      @(posedge rd_clk); #1;
      n++;
    end
    chk("wait_beat2", {63'd0, beats_seen >= 2}, 64'd1);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge rd_clk);
      chk("stall_data", {32'd0, m_data}, 64'hB2);
    end
    @(posedge rd_clk); #1;
    m_ready = 1'b1;
    wait_done(60, 0);
    chk("b8_beats", 64'(beats_seen), 64'd8);
    chk("b8_rd_cnt", 64'(rd_cnt), 64'd8);

    // empty flag toggling every cycle
    tog_en = 1;
    load(8, 1, 0);
    issue(7);
    wait_done(100, 0);
    tog_en = 0;
    chk("tog_beats", 64'(beats_seen), 64'd8);

    // single beat
    load(1, 1, 0);
    issue(0);
    wait_done(20, 0);
    chk("one_beats", 64'(beats_seen), 64'd1);
    chk("one_rd_cnt", 64'(rd_cnt), 64'd1);

    // maximum burst, counters must not wrap
    load(256, 1, 0);
    issue(255);
    wait_done(600, 0);
    chk("max_beats", 64'(beats_seen), 64'd256);
    chk("max_rd_cnt", 64'(rd_cnt), 64'd256);
    chk("max_fifo_left", 64'(fq.size()), 64'd0);

    // randomized bursts with random backpressure and stray commands
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(0, 12);
      load(len + 1, 1, 0);
      issue(len);
      wait_done(400, 1);
      chk("rnd_beats", 64'(beats_seen), 64'(len + 1));
      chk("rnd_rd_cnt", 64'(rd_cnt), 64'(len + 1));
      chk("rnd_exp_left", 64'(exp_q.size()), 64'd0);
    end

    // reset mid-burst
    load(8, 1, 0);
    issue(7);
    n = 0;
    while (beats_seen < 2 && n < 50) begin
      @(posedge rd_clk); #1;
      n++;
    end
    chk("wait_rst_point", {63'd0, beats_seen >= 2}, 64'd1);
    reset = 1'b1;
    @(posedge rd_clk); #1;
    reset = 1'b0;
    @(negedge rd_clk);
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    fq.delete();
    exp_q.delete();
    load(3, 1, 0);
    issue(1);
    wait_done(30, 0);
    repeat (3) @(negedge rd_clk);
    chk("post_rst_beats", 64'(beats_seen), 64'd2);
    chk("post_rst_rd_cnt", 64'(rd_cnt), 64'd2);
    chk("post_rst_fifo_left", 64'(fq.size()), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
